multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/mips_ctrl_pkg.sv | 57 +++++
 rtl/ctrl_out_decode.sv | 69 ++++++
 rtl/multicycle_control.sv | 95 +++++++++
 tb/tb_multicycle_control.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit and its datapath.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_HALT    = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write_cond;
    logic       pc_write;
    logic       i_or_d;
    logic       mem_to_reg;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/ctrl_out_decode.sv
// Pure state-to-control decode; Moore outputs depend on state only.
// ADDIEX/ADDIWB decode exists only when MIPS_CTRL_ADDI_EN is defined.
module ctrl_out_decode
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_IMMSH;
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
`ifdef MIPS_CTRL_ADDI_EN
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
`endif
      S_HALT: ctrl.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with fetched-instruction counter.
// Optional ADDI support is enabled by defining MIPS_CTRL_ADDI_EN.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned HALT_ON_ILLEGAL = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  output logic        PCWriteCond,
  output logic        PCWrite,
  output logic        IorD,
  output logic        MemToReg,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        ALUSrcA,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [1:0]  PCSource,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [3:0]  state,
  output logic        halted,
  output logic [31:0] instr_count
);

  localparam state_t ILLEGAL_NEXT = (HALT_ON_ILLEGAL != 0) ? S_HALT : S_FETCH;

  state_t      state_reg;
  logic [31:0] count_reg;
  state_t      decode_state;
  ctrl_t       ctrl;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_FETCH;
      count_reg <= '0;
    end else begin
      case (state_reg)
        S_FETCH: begin
          state_reg <= S_DECODE;
          count_reg <= count_reg + 32'd1;
        end
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: state_reg <= S_MEMADR;
            OP_R:         state_reg <= S_EXECUTE;
            OP_BEQ:       state_reg <= S_BRANCH;
            OP_J:         state_reg <= S_JUMP;
`ifdef MIPS_CTRL_ADDI_EN
            OP_ADDI:      state_reg <= S_ADDIEX;
`endif
            default:      state_reg <= ILLEGAL_NEXT;
          endcase
        end
        S_MEMADR:  state_reg <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:   state_reg <= S_MEMWB;
        S_EXECUTE: state_reg <= S_ALUWB;
`ifdef MIPS_CTRL_ADDI_EN
        S_ADDIEX:  state_reg <= S_ADDIWB;
`endif
        S_HALT:    state_reg <= S_HALT;
        default:   state_reg <= S_FETCH;
      endcase
    end
  end

  // While reset is held the outputs look like a FETCH with every enable suppressed.
  assign decode_state = reset ? S_FETCH : state_reg;

  ctrl_out_decode u_decode (
    .state (decode_state),
    .ctrl  (ctrl)
  );

  assign PCWriteCond = ctrl.pc_write_cond & ~reset;
  assign PCWrite     = ctrl.pc_write & ~reset;
  assign IRWrite     = ctrl.ir_write & ~reset;
  assign RegWrite    = ctrl.reg_write & ~reset;
  assign MemRead     = ctrl.mem_read & ~reset;
  assign MemWrite    = ctrl.mem_write & ~reset;
  assign IorD        = ctrl.i_or_d;
  assign MemToReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign PCSource    = ctrl.pc_source;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign halted      = ctrl.halted;
  assign state       = state_reg;
  assign instr_count = count_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: one instance per HALT_ON_ILLEGAL value, checked
// against an instruction-route model; honours MIPS_CTRL_ADDI_EN like the design.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'h00;

  logic [3:0]  st_o   [2];
  logic [15:0] ctrl_o [2];
  logic        halt_o [2];
  logic [31:0] cnt_o  [2];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic pcwc, pcw, iord, m2r, irw, rw, rd, asa, mr, mw;
    logic [1:0] pcs, asb, aop;
    multicycle_control #(.HALT_ON_ILLEGAL(gi)) u_dut (
      .clk(clk), .reset(reset), .op(op),
      .PCWriteCond(pcwc), .PCWrite(pcw), .IorD(iord), .MemToReg(m2r),
      .IRWrite(irw), .RegWrite(rw), .RegDst(rd), .ALUSrcA(asa),
      .MemRead(mr), .MemWrite(mw), .PCSource(pcs), .ALUSrcB(asb),
      .ALUOp(aop), .state(st_o[gi]), .halted(halt_o[gi]), .instr_count(cnt_o[gi])
    );
    assign ctrl_o[gi] = {pcwc, pcw, iord, m2r, irw, rw, rd, asa, mr, mw, pcs, asb, aop};
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, one slot per instance (index = HALT_ON_ILLEGAL).
  int          m_st  [2];
  int          m_pos [2];
  logic [5:0]  m_op  [2];
  logic [31:0] m_cnt [2];
  bit          m_valid = 0;

  // Latency tracker on the HALT_ON_ILLEGAL=0 instance.
  bit         lat_busy = 0;
  int         lat = 0;
  logic [5:0] lat_op = 6'h00;

  // States visited after FETCH for an instruction; 0 past the end means back to FETCH.
  function automatic int route_at(input logic [5:0] o, input int hp, input int idx);
    int r[$];
    case (o)
      6'h23: r = '{1, 2, 3, 4};
      6'h2B: r = '{1, 2, 5};
      6'h00: r = '{1, 6, 7};
      6'h04: r = '{1, 8};
      6'h02: r = '{1, 9};
`ifdef MIPS_CTRL_ADDI_EN
      6'h08: r = '{1, 10, 11};
`endif
      default: if (hp != 0) r = '{1, 12}; else r = '{1};
    endcase
    return (idx < r.size()) ? r[idx] : 0;
  endfunction

  function automatic int exp_lat(input logic [5:0] o);
    case (o)
      6'h23: return 5;
      6'h2B: return 4;
      6'h00: return 4;
      6'h04: return 3;
      6'h02: return 3;
`ifdef MIPS_CTRL_ADDI_EN
      6'h08: return 4;
`endif
      default: return 2;
    endcase
  endfunction

  function automatic logic [15:0] exp_ctrl(input int st_in, input bit rst);
    bit pcwc, pcw, iord, m2r, irw, rw, rd, asa, mr, mw;
    bit [1:0] pcs, asb, aop;
    int st;
    {pcwc, pcw, iord, m2r, irw, rw, rd, asa, mr, mw} = '0;
    pcs = 2'd0; asb = 2'd0; aop = 2'd0;
    st = rst ? 0 : st_in;
    case (st)
      0:  begin mr = 1; irw = 1; pcw = 1; asb = 2'b01; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iord = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      9:  begin pcw = 1; pcs = 2'b10; end
      10: begin asa = 1; asb = 2'b10; end
      11: rw = 1;
      default: ;
    endcase
    if (rst) {pcw, pcwc, irw, rw, mr, mw} = '0;
    return {pcwc, pcw, iord, m2r, irw, rw, rd, asa, mr, mw, pcs, asb, aop};
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[hoi=%0d] observed=%h expected=%h (t=%0t)", tag, k, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk("state", k, {28'd0, st_o[k]}, m_st[k]);
      chk("ctrl", k, {16'd0, ctrl_o[k]}, {16'd0, exp_ctrl(m_st[k], reset)});
      chk("halted", k, {31'd0, halt_o[k]}, {31'd0, (m_st[k] == 12) && !reset});
      chk("instr_count", k, cnt_o[k], m_cnt[k]);
    end
    if (reset) begin
      lat_busy = 0;
    end else if (st_o[0] == 4'd0) begin
      if (lat_busy) chk("latency", 0, lat, exp_lat(lat_op));
      lat_busy = 1;
      lat = 1;
    end else begin
      if (st_o[0] == 4'd1) lat_op = op;
      lat++;
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_st[k] = 0; m_cnt[k] = '0; m_pos[k] = 0;
      end else if (m_st[k] == 12) begin
        m_st[k] = 12;
      end else if (m_st[k] == 0) begin
        m_cnt[k] = m_cnt[k] + 32'd1;
        m_op[k]  = op;
        m_pos[k] = 0;
        m_st[k]  = route_at(op, k, 0);
      end else begin
        m_pos[k]++;
        m_st[k] = route_at(m_op[k], k, m_pos[k]);
      end
    end
    m_valid = 1;
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cycle(input logic r, input logic [5:0] o);
    reset = r;
    op = o;
    #1;
    if (m_valid) check_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic run_op(input logic [5:0] o, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, o);
  endtask

  initial begin
    logic [5:0] ops [6];
    logic [5:0] rop;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
    @(negedge clk);
    cycle(1'b1, 6'h00);
    cycle(1'b1, 6'h00);
    run_op(6'h23, 5);
    run_op(6'h2B, 4);
    run_op(6'h04, 3);
    run_op(6'h02, 3);
    run_op(6'h00, 4);
    run_op(6'h08, exp_lat(6'h08));
    // Illegal opcode: one instance keeps cycling, the other parks in HALT.
    run_op(6'h3F, 22);
    cycle(1'b1, 6'h3F);
    run_op(6'h3F, 2);
    run_op(6'h23, 3);
    // Reset arriving while in MEMRD.
    cycle(1'b1, 6'h23);
    cycle(1'b1, 6'h23);
    // Counter wrap from all-ones on the next FETCH edge.
    force g_dut[0].u_dut.count_reg = 32'hFFFF_FFFF;
    force g_dut[1].u_dut.count_reg = 32'hFFFF_FFFF;
    reset = 1'b0;
    #1;
    release g_dut[0].u_dut.count_reg;
    release g_dut[1].u_dut.count_reg;
    m_cnt[0] = 32'hFFFF_FFFF;
    m_cnt[1] = 32'hFFFF_FFFF;
    run_op(6'h02, 3);
    chk("wrap", 0, cnt_o[0], 32'd0);
    // Randomised instruction stream with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if (m_st[0] == 0) begin
        if ($urandom_range(0, 6) == 6) rop = 6'($urandom_range(0, 63));
        else rop = ops[$urandom_range(0, 5)];
      end else begin
        rop = op;
      end
      cycle($urandom_range(0, 49) == 0, rop);
    end
    cycle(1'b0, op);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
